// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit:
// funct3 operation codes, FSM states and the iteration count.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam int ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_sign.sv
// Combinational sign handling: operand magnitudes and sign flags on entry,
// sign correction and result selection on exit.
module muldiv_sign
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op_in,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b,
    output logic            neg_res,
    output logic            neg_rem,
    input  logic [2:0]      op_lat,
    input  logic            neg_res_lat,
    input  logic            neg_rem_lat,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] res_out
);

    logic                   a_sgn;
    logic                   b_sgn;
    logic                   a_neg;
    logic                   b_neg;
    logic signed [2*XLEN-1:0] prod_fix;
    logic signed [XLEN-1:0]   quot_fix;
    logic signed [XLEN-1:0]   rem_fix;

    always_comb begin
        // Divides: DIV/REM signed (op[0]=0). Multiplies: a signed unless MULHU, b signed for MUL/MULH.
        a_sgn   = op_in[2] ? ~op_in[0] : (op_in != OP_MULHU);
        b_sgn   = op_in[2] ? ~op_in[0] : ~op_in[1];
        a_neg   = a_sgn & a_in[XLEN-1];
        b_neg   = b_sgn & b_in[XLEN-1];
        mag_a   = a_neg ? -a_in : a_in;
        mag_b   = b_neg ? -b_in : b_in;
        neg_res = a_neg ^ b_neg;
        neg_rem = a_neg;
    end

    always_comb begin
        prod_fix = neg_res_lat ? -$signed({hi, lo}) : $signed({hi, lo});
        quot_fix = neg_res_lat ? -$signed(lo) : $signed(lo);
        rem_fix  = neg_rem_lat ? -$signed(hi) : $signed(hi);
        res_out  = '0;
        case (op_lat)
            OP_MUL:                       res_out = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res_out = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              res_out = quot_fix;
            OP_REM, OP_REMU:              res_out = rem_fix;
            default:                      res_out = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, iteration counter and a shared
// hi/lo shift datapath (shift-add multiply, restoring divide).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    localparam logic [4:0] CNT_LAST = 5'(ITERS - 1);

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [2:0]      op_q, op_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opb_q, opb_d;

    logic [XLEN-1:0] mag_a, mag_b;
    logic            neg_res_in, neg_rem_in;
    logic [XLEN-1:0] res_out;

    logic [XLEN-1:0] step_hi, step_lo;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN+1:0] div_diff;
    logic            div_ok;

    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_res;

    muldiv_sign #(.XLEN(XLEN)) u_sign (
        .op_in       (op),
        .a_in        (a),
        .b_in        (b),
        .mag_a       (mag_a),
        .mag_b       (mag_b),
        .neg_res     (neg_res_in),
        .neg_rem     (neg_rem_in),
        .op_lat      (op_q),
        .neg_res_lat (neg_res_q),
        .neg_rem_lat (neg_rem_q),
        .hi          (step_hi),
        .lo          (step_lo),
        .res_out     (res_out)
    );

    // Multiply: hi:lo holds partial product and shifting multiplier, opb the multiplicand.
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in, opb the divisor.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
        div_ok    = ~div_diff[XLEN+1];
        if (op_q[2]) begin
            step_hi = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ok};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_comb begin
        div_zero = op[2] & (b == '0);
        div_ovf  = op[2] & ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);
        fast     = div_zero | div_ovf;
        if (div_zero) begin
            fast_res = op[1] ? a : '1;
        end else begin
            fast_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opb_d     = opb_q;
        case (state_q)
            ST_IDLE: begin
                if (start & ~kill) begin
                    op_d      = op;
                    neg_res_d = neg_res_in;
                    neg_rem_d = neg_rem_in;
                    cnt_d     = '0;
                    if (fast) begin
                        state_d  = ST_DONE;
                        result_d = fast_res;
                    end else begin
                        state_d = ST_RUN;
                        hi_d    = '0;
                        lo_d    = op[2] ? mag_a : mag_b;
                        opb_d   = op[2] ? mag_b : mag_a;
                    end
                end
            end
            ST_RUN: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = ST_DONE;
                        result_d = res_out;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q      <= op_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
        hi_q      <= hi_d;
        lo_q      <= lo_d;
        opb_q     <= opb_d;
    end

    assign busy   = (state_q != ST_IDLE);
    assign valid  = (state_q == ST_DONE) & ~kill;
    assign result = result_q;

endmodule
